// File: rtl/rv_pipe_pkg.sv
// Shared pipeline constants for the fetch front end: default XLEN, canonical NOP,
// IMEM read latency and the bit layout of a queued fetch entry.
package rv_pipe_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam logic [31:0] RV_NOP = 32'h0000_0013;
  localparam int IMEM_LAT = 1;

  // Fetch entry = {pc, instr}; instr occupies the low 32 bits
  localparam int ENT_INSTR_LSB = 0;
  localparam int ENT_INSTR_W   = 32;
  localparam int ENT_PC_LSB    = ENT_INSTR_LSB + ENT_INSTR_W;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Fetch front-end bus: IMEM request/response, redirect from ID and the decode handshake.
// master = fetch unit side, slave = core/memory side.
interface fetch_queue_unit_if
  import rv_pipe_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int IADDR_W = 14
);
  logic               imem_req;
  logic [IADDR_W-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               redirect;
  logic [XLEN-1:0]    redirect_pc;
  logic               dec_valid;
  logic               dec_ready;
  logic [31:0]        dec_instr;
  logic [XLEN-1:0]    dec_pc;

  modport master (
    output imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
    input  imem_rdata, redirect, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
    output imem_rdata, redirect, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Generic DEPTH x W synchronous FIFO with flush; DEPTH must be a power of two so the
// pointers wrap naturally. A push while full is only taken when a pop frees the slot.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 96
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the PC, issues 1-cycle IMEM reads under a credit
// rule and queues {pc, instr} for decode. Define FQ_BYPASS_EN for the empty-queue bypass.
module fetch_queue_unit
  import rv_pipe_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter int              IADDR_W  = 14,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  fetch_queue_unit_if.master      bus,
  output logic [XLEN-1:0]         fetch_pc,
  output logic [$clog2(DEPTH):0]  occupancy
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam int EW = XLEN + ENT_INSTR_W;

  logic [XLEN-1:0] pc, req_pc;
  logic            inflight, issue, pop, push, fifo_pop, fifo_full, fifo_empty;
  logic [EW-1:0]   wdata, head, entry_out;
  logic [SW-1:0]   used, cap;

  assign pop  = bus.dec_valid & bus.dec_ready;
  // Queue slots plus the outstanding read must fit once this cycle's pop is accounted for
  assign used  = SW'(occupancy) + SW'(inflight);
  assign cap   = SW'(DEPTH) + SW'(pop);
  assign issue = reset & ~bus.redirect & (used < cap);

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc[IADDR_W+1:2];
  assign fetch_pc      = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else if (bus.redirect) begin
      pc       <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc     <= pc + XLEN'(4);
        req_pc <= pc;
      end
    end
  end

  assign wdata[ENT_PC_LSB +: XLEN]           = req_pc;
  assign wdata[ENT_INSTR_LSB +: ENT_INSTR_W] = bus.imem_rdata;

`ifdef FQ_BYPASS_EN
  logic bypass;
  assign bypass        = fifo_empty & inflight;
  assign bus.dec_valid = ~fifo_empty | inflight;
  assign push          = inflight & ~bus.redirect & ~(bypass & bus.dec_ready);
  assign fifo_pop      = ~fifo_empty & bus.dec_ready;
  assign entry_out     = !fifo_empty ? head : (inflight ? wdata : '0);
`else
  assign bus.dec_valid = ~fifo_empty;
  assign push          = inflight & ~bus.redirect;
  assign fifo_pop      = pop;
  assign entry_out     = fifo_empty ? '0 : head;
`endif

  assign bus.dec_pc    = entry_out[ENT_PC_LSB +: XLEN];
  assign bus.dec_instr = entry_out[ENT_INSTR_LSB +: ENT_INSTR_W];

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (bus.redirect),
    .push  (push),
    .pop   (fifo_pop),
    .wdata (wdata),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  overflow_chk: assert property (@(posedge clk) disable iff (!reset)
    !(push && fifo_full && !fifo_pop));

endmodule
